l2_spike_classifier: RTL and testbench

Readout stage directly downstream of the layer-2 neuron array. Counts output spikes per L2 neuron over a sample window and, at each end-of-sample marker, scans the counts serially to pick the winning class. Compares the winner against the one-hot training/test label and keeps running total and hit counters for accuracy measurement.

---
 rtl/l2_spike_classifier.sv | 171 +++++++++++++++++
 tb/tb_l2_spike_classifier.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/l2_spike_classifier.sv
// l2_spike_classifier: counts per-neuron L2 spikes over a sample window, then
// scans the counts serially to pick the winning class and keeps accuracy stats.
// Optional macro L2C_TIE_REJECT_EN: a maximum shared by two or more neurons
// yields no decision (class 0) instead of the lowest-index winner.
module l2_spike_classifier #(
    parameter int unsigned p_n  = 10,
    parameter int unsigned p_cw = 8,
    parameter int unsigned p_tw = 16,
    localparam int unsigned CW  = $clog2(p_n + 1)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [p_n:1]    i_spike,
    input  logic [p_n:1]    i_label,
    input  logic            i_endof_sample,
    input  logic            i_clear_stats,
    output logic            o_busy,
    output logic            o_valid,
    output logic [CW-1:0]   o_class,
    output logic            o_correct,
    output logic [p_tw-1:0] o_total,
    output logic [p_tw-1:0] o_hits
);

    typedef enum logic [1:0] {StAcc, StScan, StReport} state_e;

    state_e            state_q, state_d;
    logic [p_cw-1:0]   cnt_q [p_n:1];
    logic [p_cw-1:0]   cnt_d [p_n:1];
    logic [CW-1:0]     idx_q, idx_d;
    logic [p_cw-1:0]   max_q, max_d;
    logic [CW-1:0]     cls_q, cls_d;
    logic [p_n:1]      lbl_q, lbl_d;
    logic              valid_q, valid_d;
    logic [CW-1:0]     class_q, class_d;
    logic              correct_q, correct_d;
    logic [p_tw-1:0]   total_q, total_d;
    logic [p_tw-1:0]   hits_q, hits_d;
`ifdef L2C_TIE_REJECT_EN
    logic              tie_q, tie_d;
`endif

    logic [p_cw-1:0]   cur_cnt;
    logic              lbl_hit;
    logic [CW-1:0]     rep_class;
    logic              rep_correct;

    // Select the count under scan and the label bit addressed by the current winner
    always_comb begin
        cur_cnt = '0;
        lbl_hit = 1'b0;
        for (int unsigned k = 1; k <= p_n; k++) begin
            if (idx_q == CW'(k)) cur_cnt = cnt_q[k];
            if (cls_q == CW'(k)) lbl_hit = lbl_q[k];
        end
`ifdef L2C_TIE_REJECT_EN
        rep_class = tie_q ? '0 : cls_q;
`else
        rep_class = cls_q;
`endif
        rep_correct = (rep_class != '0) && lbl_hit;
    end

    // Next-state logic: accumulate, serial scan, single-cycle report
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        max_d     = max_q;
        cls_d     = cls_q;
        lbl_d     = lbl_q;
        valid_d   = 1'b0;
        class_d   = class_q;
        correct_d = correct_q;
        total_d   = total_q;
        hits_d    = hits_q;
`ifdef L2C_TIE_REJECT_EN
        tie_d     = tie_q;
`endif
        unique case (state_q)
            StAcc: begin
                for (int unsigned k = 1; k <= p_n; k++) begin
                    if (i_spike[k] && (cnt_q[k] != '1)) cnt_d[k] = cnt_q[k] + 1'b1;
                end
                if (i_endof_sample) begin
                    lbl_d   = i_label;
                    max_d   = '0;
                    cls_d   = '0;
                    idx_d   = CW'(1);
`ifdef L2C_TIE_REJECT_EN
                    tie_d   = 1'b0;
`endif
                    state_d = StScan;
                end
            end
            StScan: begin
                // Strict compare: zero never wins, earlier index keeps ties
                if (cur_cnt > max_q) begin
                    max_d = cur_cnt;
                    cls_d = idx_q;
`ifdef L2C_TIE_REJECT_EN
                    tie_d = 1'b0;
                end else if ((cur_cnt == max_q) && (cur_cnt != '0)) begin
                    tie_d = 1'b1;
`endif
                end
                if (idx_q == CW'(p_n)) state_d = StReport;
                else                   idx_d   = idx_q + 1'b1;
            end
            StReport: begin
                valid_d   = 1'b1;
                class_d   = rep_class;
                correct_d = rep_correct;
                if (lbl_q != '0) begin
                    if (total_q != '1) total_d = total_q + 1'b1;
                    if (rep_correct && (hits_q != '1)) hits_d = hits_q + 1'b1;
                end
                cnt_d   = '{default: '0};
                state_d = StAcc;
            end
            default: state_d = StAcc;
        endcase
        if (i_clear_stats) begin
            total_d = '0;
            hits_d  = '0;
        end
    end

    // State and datapath registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= StAcc;
            cnt_q     <= '{default: '0};
            idx_q     <= '0;
            max_q     <= '0;
            cls_q     <= '0;
            lbl_q     <= '0;
            valid_q   <= 1'b0;
            class_q   <= '0;
            correct_q <= 1'b0;
            total_q   <= '0;
            hits_q    <= '0;
`ifdef L2C_TIE_REJECT_EN
            tie_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            max_q     <= max_d;
            cls_q     <= cls_d;
            lbl_q     <= lbl_d;
            valid_q   <= valid_d;
            class_q   <= class_d;
            correct_q <= correct_d;
            total_q   <= total_d;
            hits_q    <= hits_d;
`ifdef L2C_TIE_REJECT_EN
            tie_q     <= tie_d;
`endif
        end
    end

    assign o_busy    = (state_q != StAcc);
    assign o_valid   = valid_q;
    assign o_class   = class_q;
    assign o_correct = correct_q;
    assign o_total   = total_q;
    assign o_hits    = hits_q;

endmodule

// File: tb/tb_l2_spike_classifier.sv
// Self-checking bench for l2_spike_classifier: table-driven windows, hand-written
// corner sequences and randomized windows checked against a behavioural model.
module tb_l2_spike_classifier;

    localparam int P_N  = 10;
    localparam int P_CW = 8;
    localparam int P_TW = 16;
    localparam int CW   = 4;
    localparam int CMAX = 2 ** P_CW - 1;
    localparam logic [P_N:1] NONE = '0;
`ifdef L2C_TIE_REJECT_EN
    localparam bit TIE_REJ = 1'b1;
`else
    localparam bit TIE_REJ = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [P_N:1]    spike, label;
    logic            endof, clr;
    logic            busy, valid, correct;
    logic [CW-1:0]   cls;
    logic [P_TW-1:0] total, hits;

    always #5 clk = ~clk;

    l2_spike_classifier #(.p_n(P_N), .p_cw(P_CW), .p_tw(P_TW)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_spike        (spike),
        .i_label        (label),
        .i_endof_sample (endof),
        .i_clear_stats  (clr),
        .o_busy         (busy),
        .o_valid        (valid),
        .o_class        (cls),
        .o_correct      (correct),
        .o_total        (total),
        .o_hits         (hits)
    );

    int vectors = 0;
    int miscompares = 0;
    int m_cnt [1:P_N];
    int m_total = 0;
    int m_hits = 0;

    typedef struct {
        logic [P_N:1] ma;
        int           ra;
        logic [P_N:1] mb;
        int           rb;
        logic [P_N:1] me;
        logic [P_N:1] lbl;
        int           ec;
        bit           ecor;
    } vec_t;
    vec_t tab [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [P_N:1] oh(input int n);
        logic [P_N:1] v;
        v = '0;
        if (n > 0) v[n] = 1'b1;
        return v;
    endfunction

    // Reference classifier: largest count wins, lowest index on ties, zero is no decision
    function automatic void model_class(input logic [P_N:1] lbl, output int c, output bit cor);
        int mx, n;
        mx = 0; n = 0; c = 0;
        for (int k = 1; k <= P_N; k++) if (m_cnt[k] > mx) mx = m_cnt[k];
        if (mx > 0) begin
            for (int k = P_N; k >= 1; k--) if (m_cnt[k] == mx) begin c = k; n++; end
            if (TIE_REJ && n > 1) c = 0;
        end
        cor = (c != 0) && lbl[c];
    endfunction

    task automatic cyc_spikes(input logic [P_N:1] mask, input int reps);
        repeat (reps) begin
            @(negedge clk);
            spike = mask;
            for (int k = 1; k <= P_N; k++) if (mask[k] && m_cnt[k] < CMAX) m_cnt[k]++;
        end
    endtask

    task automatic count_valids(input string name, input int cycles);
        int n;
        n = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (valid) n++;
        end
        chk(name, n, 0);
    endtask

    // Close the window and check the report; junk floods spikes/endof while busy,
    // clr_rep pulses i_clear_stats on the report edge
    task automatic end_check(input string name, input logic [P_N:1] endmask,
                             input logic [P_N:1] lbl, input int exp_c, input bit exp_cor,
                             input bit junk, input bit clr_rep);
        int k;
        bit got;
        @(negedge clk);
        spike = endmask; label = lbl; endof = 1'b1;
        @(negedge clk);
        spike = '0; endof = 1'b0; label = '0;
        chk({name, "_busy"}, busy, 1);
        k = 0; got = 1'b0;
        while (!got && k < 30) begin
            if (valid) got = 1'b1;
            else begin
                if (junk) begin spike = '1; endof = 1'b1; end
                clr = clr_rep && (k == P_N);
                @(negedge clk);
                k++;
            end
        end
        spike = '0; endof = 1'b0; clr = 1'b0;
        if (!got) chk({name, "_valid_timeout"}, 0, 1);
        chk({name, "_latency"}, k, P_N + 1);
        if (clr_rep) begin
            m_total = 0; m_hits = 0;
        end else if (lbl != '0) begin
            m_total++;
            if (exp_cor) m_hits++;
        end
        chk({name, "_class"}, cls, exp_c);
        chk({name, "_correct"}, correct, exp_cor);
        chk({name, "_total"}, total, m_total);
        chk({name, "_hits"}, hits, m_hits);
        @(negedge clk);
        chk({name, "_valid_pulse"}, valid, 0);
        for (int j = 1; j <= P_N; j++) m_cnt[j] = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c;
        bit cor;
        logic [P_N:1] lbl, mask;

        for (int k = 1; k <= P_N; k++) m_cnt[k] = 0;
        tab[0] = '{oh(4) | oh(7), 1, oh(4), 2, NONE, oh(4), 4, 1'b1};
        tab[1] = '{oh(2) | oh(5), 2, NONE, 0, NONE, oh(5), TIE_REJ ? 0 : 2, 1'b0};
        tab[2] = '{oh(1) | oh(3), 256, oh(1), 44, NONE, oh(1), TIE_REJ ? 0 : 1, !TIE_REJ};
        tab[3] = '{NONE, 0, NONE, 0, NONE, NONE, 0, 1'b0};
        tab[4] = '{oh(9), 1, NONE, 0, oh(9) | oh(10), oh(9), 9, 1'b1};
        tab[5] = '{oh(6), 3, NONE, 0, NONE, oh(6) | oh(2), 6, 1'b1};
        tab[6] = '{oh(10) | oh(8), 1, oh(8), 1, NONE, oh(3), 8, 1'b0};

        // Reset held while spikes toggle
        rst = 1'b1; spike = '0; label = '0; endof = 1'b0; clr = 1'b0;
        repeat (5) @(negedge clk) spike = P_N'($urandom);
        chk("rst_busy", busy, 0);
        chk("rst_valid", valid, 0);
        chk("rst_class", cls, 0);
        chk("rst_correct", correct, 0);
        chk("rst_total", total, 0);
        chk("rst_hits", hits, 0);
        @(negedge clk);
        spike = '0; rst = 1'b0;
        count_valids("idle_no_valid", 4);

        for (int i = 0; i < 7; i++) begin
            cyc_spikes(tab[i].ma, tab[i].ra);
            cyc_spikes(tab[i].mb, tab[i].rb);
            end_check($sformatf("tab%0d", i), tab[i].me, tab[i].lbl, tab[i].ec, tab[i].ecor,
                      1'b0, 1'b0);
        end

        // Spikes and endof while busy are dropped; clear wins over the report update
        cyc_spikes(oh(3), 2);
        end_check("junk", NONE, oh(3), 3, 1'b1, 1'b1, 1'b1);
        count_valids("junk_single_valid", 15);
        cyc_spikes(oh(5), 1);
        end_check("after_junk", NONE, oh(5), 5, 1'b1, 1'b0, 1'b0);

        // Reset while scanning idx 5
        cyc_spikes(oh(2), 3);
        @(negedge clk);
        spike = '0; endof = 1'b1; label = oh(2);
        @(negedge clk);
        endof = 1'b0; label = '0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_class", cls, 0);
        chk("midrst_correct", correct, 0);
        chk("midrst_total", total, 0);
        chk("midrst_hits", hits, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= P_N; k++) m_cnt[k] = 0;
        m_total = 0; m_hits = 0;
        count_valids("midrst_no_valid", 15);

        // Randomized windows against the reference model
        for (int w = 0; w < 25; w++) begin
            repeat ($urandom_range(0, 25)) begin
                for (int k = 1; k <= P_N; k++) mask[k] = ($urandom_range(0, 3) == 0);
                cyc_spikes(mask, 1);
            end
            case ($urandom_range(0, 3))
                0:       lbl = '0;
                3:       lbl = P_N'($urandom);
                default: lbl = oh($urandom_range(1, P_N));
            endcase
            model_class(lbl, c, cor);
            end_check($sformatf("rnd%0d", w), NONE, lbl, c, cor, 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
